// File: rtl/lc_transition_ctrl.sv
// Lifecycle transition controller.
// Accepts a request for a target lifecycle state. It then collects a WIDTH-bit unlock token,
// which arrives in BEAT-bit beats with the least-significant beat first. It reads the reference
// token for the target from the token ROM and compares the two. On a match it advances lc_state.
// Each mismatch is counted. When MAX_FAIL mismatches have been counted, the controller locks
// out until reset.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_target is the requested state
//   tok_valid/tok_ready         token beat handshake; tok_data is one beat
//   mem_rd_en/mem_addr          ROM read request
//   mem_rdData/mem_valid        ROM read response
//   lc_state                    current lifecycle state
//   done                        one-cycle pulse when a request finishes
//   pass, err                   result of the last request (err: 0 ok, 1 illegal,
//                               2 mismatch, 3 timeout)
//   fail_cnt, locked            accumulated mismatches, permanent lockout
module lc_transition_ctrl #(
  parameter int unsigned WIDTH    = 256,
  parameter int unsigned LENGTH   = 6,
  parameter int unsigned BEAT     = 32,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned TIMEOUT  = 8,
  localparam int unsigned AW      = $clog2(LENGTH),
  localparam int unsigned FW      = $clog2(MAX_FAIL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_target,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [BEAT-1:0]  tok_data,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdData,
  input  logic             mem_valid,
  output logic [AW-1:0]    lc_state,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err,
  output logic [FW-1:0]    fail_cnt,
  output logic             locked
);

  localparam int unsigned NBeats = WIDTH / BEAT;
  localparam int unsigned BW     = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ErrOk       = 2'd0;
  localparam logic [1:0] ErrIllegal  = 2'd1;
  localparam logic [1:0] ErrMismatch = 2'd2;
  localparam logic [1:0] ErrTimeout  = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StCheck, StCollect, StRead, StWait, StCompare, StDone, StLock
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    target_q, target_d;
  logic [AW-1:0]    lc_state_q, lc_state_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [FW-1:0]    fail_cnt_q, fail_cnt_d;
  logic             locked_q, locked_d;
  logic             pass_q, pass_d;
  logic [1:0]       err_q, err_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] tok_q, tok_d;
  logic [WIDTH-1:0] rom_q, rom_d;
  // Provides the single done pulse that accompanies entry into StLock.
  logic             lock_pulse_q, lock_pulse_d;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    lc_state_d   = lc_state_q;
    mem_addr_d   = mem_addr_q;
    fail_cnt_d   = fail_cnt_q;
    locked_d     = locked_q;
    pass_d       = pass_q;
    err_d        = err_q;
    beat_cnt_d   = beat_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    tok_d        = tok_q;
    rom_d        = rom_q;
    lock_pulse_d = 1'b0;
    req_ready    = 1'b0;
    tok_ready    = 1'b0;
    mem_rd_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          target_d = req_target;
          pass_d   = 1'b0;
          err_d    = ErrOk;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        // Transitions only move forward, so state 0 is never a legal target.
        if ((target_q > lc_state_q) && (32'(target_q) < LENGTH)) begin
          beat_cnt_d = '0;
          state_d    = StCollect;
        end else begin
          err_d   = ErrIllegal;
          state_d = StDone;
        end
      end
      StCollect: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          tok_d[beat_cnt_q*BEAT +: BEAT] = tok_data;
          if (beat_cnt_q == BW'(NBeats - 1)) begin
            beat_cnt_d = '0;
            mem_addr_d = target_q;
            state_d    = StRead;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end
      StRead: begin
        mem_rd_en  = 1'b1;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (mem_valid) begin
          rom_d   = mem_rdData;
          state_d = StCompare;
        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = ErrTimeout;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      StCompare: begin
        if (tok_q == rom_q) begin
          lc_state_d = target_q;
          pass_d     = 1'b1;
          err_d      = ErrOk;
          state_d    = StDone;
        end else begin
          fail_cnt_d = fail_cnt_q + FW'(1);
          err_d      = ErrMismatch;
          if (fail_cnt_q == FW'(MAX_FAIL - 1)) begin
            locked_d     = 1'b1;
            lock_pulse_d = 1'b1;
            state_d      = StLock;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StLock: begin
        state_d = StLock;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      target_q     <= '0;
      lc_state_q   <= '0;
      mem_addr_q   <= '0;
      fail_cnt_q   <= '0;
      locked_q     <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= ErrOk;
      beat_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      tok_q        <= '0;
      rom_q        <= '0;
      lock_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      lc_state_q   <= lc_state_d;
      mem_addr_q   <= mem_addr_d;
      fail_cnt_q   <= fail_cnt_d;
      locked_q     <= locked_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      beat_cnt_q   <= beat_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      tok_q        <= tok_d;
      rom_q        <= rom_d;
      lock_pulse_q <= lock_pulse_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign lc_state = lc_state_q;
  assign done     = (state_q == StDone) | lock_pulse_q;
  assign pass     = pass_q;
  assign err      = err_q;
  assign fail_cnt = fail_cnt_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_lc_transition_ctrl.sv
// Directed testbench for lc_transition_ctrl.
// It includes a behavioural token ROM that answers one cycle after mem_rd_en. The ROM can be
// silenced to force a timeout. It can also inject stray mem_valid pulses.
module tb_lc_transition_ctrl;

  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_target = '0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic [31:0]  tok_data = '0;
  logic         mem_rd_en;
  logic [2:0]   mem_addr;
  logic [255:0] mem_rdData = '0;
  logic         mem_valid = 1'b0;
  logic [2:0]   lc_state;
  logic         done;
  logic         pass;
  logic [1:0]   err;
  logic [1:0]   fail_cnt;
  logic         locked;

  int total = 0;
  int bad   = 0;

  logic         rom_on  = 1'b1;
  logic         junk_mv = 1'b0;
  logic [255:0] rom [8];

  lc_transition_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_data   (tok_data),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdData (mem_rdData),
    .mem_valid  (mem_valid),
    .lc_state   (lc_state),
    .done       (done),
    .pass       (pass),
    .err        (err),
    .fail_cnt   (fail_cnt),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // ROM model: samples the read request at the edge and responds in the following cycle.
  always @(posedge clk) begin : rom_model
    logic       rd;
    logic       jv;
    logic [2:0] a;
    rd = mem_rd_en;
    jv = junk_mv;
    a  = mem_addr;
    #1;
    mem_valid  = (rd && rom_on) || jv;
    mem_rdData = rd ? rom[a] : {8{32'hdeadbeef}};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and streams the token whenever tok_ready is high. It returns the number
  // of cycles from accept to done; the value reaches the bound if done never comes. With junk
  // set, it drives stray tok_valid in IDLE/CHECK and stray mem_valid during COLLECT.
  task automatic run_req(input logic [2:0] tgt, input logic [255:0] tok, input bit junk,
                         output int lat, output bit saw_tr, output bit saw_rd);
    int k;
    k      = 0;
    lat    = 0;
    saw_tr = 1'b0;
    saw_rd = 1'b0;
    for (int i = 0; i < 4 && !req_ready; i++) tick();
    req_valid  = 1'b1;
    req_target = tgt;
    if (junk) begin
      tok_valid = 1'b1;
      tok_data  = 32'hbad00001;
    end
    tick();
    req_valid  = 1'b0;
    req_target = ~tgt;
    while (lat < 40) begin
      lat++;
      if (tok_ready) saw_tr = 1'b1;
      if (mem_rd_en) saw_rd = 1'b1;
      if (done) break;
      if (tok_ready && k < NB) begin
        tok_valid = 1'b1;
        tok_data  = tok[k*32 +: 32];
        junk_mv   = junk;
        k++;
      end else if (junk && k == 0) begin
        tok_valid = 1'b1;
        tok_data  = 32'hbad00002;
        junk_mv   = 1'b0;
      end else begin
        tok_valid = 1'b0;
        junk_mv   = 1'b0;
      end
      tick();
    end
    tok_valid = 1'b0;
    junk_mv   = 1'b0;
  endtask

  initial begin
    int           lat;
    bit           str;
    bit           srd;
    int           beats;
    logic [2:0]   ill [3];
    logic [255:0] wrong;

    rom[0] = '0;
    rom[1] = 256'h33a344a3_5c1e9d07_8b2f6a11_0d94c3e8_71a5b2f6_c9e0473d_2b8d16fa_ea56a24a;
    rom[2] = 256'h9f31c0de_44aa8e17_b3076c52_e1d9fa03_5a6b7c8d_0f1e2d3c_a5c35a3c_7e11d00f;
    rom[3] = {8{32'h13579bdf}};
    rom[4] = {8{32'h2468ace0}};
    rom[5] = {8{32'h0badcafe}};
    rom[6] = {8{32'hfeedf00d}};
    rom[7] = {8{32'h01234567}};
    ill[0] = 3'd1;
    ill[1] = 3'd0;
    ill[2] = 3'd7;

    // Reset state
    tick();
    tick();
    check("rst_lc_state", lc_state, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_locked", locked, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_tok_ready", tok_ready, 0);
    check("rst_req_ready", req_ready, 1);
    rst = 1'b0;

    // 1: correct token for target 1
    run_req(3'd1, rom[1], 1'b0, lat, str, srd);
    check("t1_latency", lat, 13);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_err", err, 0);
    check("t1_lc_state", lc_state, 1);
    check("t1_fail_cnt", fail_cnt, 0);
    check("t1_saw_rd", srd, 1);
    tick();
    check("t1_done_low", done, 0);
    check("t1_pass_hold", pass, 1);
    check("t1_req_ready", req_ready, 1);

    // 2: illegal targets (same, backwards, out of range)
    for (int i = 0; i < 3; i++) begin
      run_req(ill[i], rom[1], 1'b0, lat, str, srd);
      check("t2_latency", lat, 2);
      check("t2_err", err, 1);
      check("t2_pass", pass, 0);
      check("t2_no_tok_ready", str, 0);
      check("t2_no_rd_en", srd, 0);
      check("t2_lc_state", lc_state, 1);
    end

    // 3: three mismatches lead to lockout
    wrong = rom[2] ^ 256'h10000;
    for (int i = 0; i < 3; i++) begin
      run_req(3'd2, wrong, 1'b0, lat, str, srd);
      check("t3_latency", lat, 13);
      check("t3_done", done, 1);
      check("t3_err", err, 2);
      check("t3_pass", pass, 0);
      check("t3_fail_cnt", fail_cnt, i + 1);
      check("t3_locked", locked, (i == 2) ? 1 : 0);
      check("t3_lc_state", lc_state, 1);
    end
    req_valid  = 1'b1;
    req_target = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_lock_req_ready", req_ready, 0);
      check("t3_lock_tok_ready", tok_ready, 0);
      check("t3_lock_done", done, 0);
      check("t3_lock_rd_en", mem_rd_en, 0);
    end
    req_valid = 1'b0;
    check("t3_lock_lc_state", lc_state, 1);
    check("t3_lock_locked", locked, 1);

    // 4: one mismatch, then a ROM timeout that leaves fail_cnt alone
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_req(3'd1, rom[1] ^ 256'h1, 1'b0, lat, str, srd);
    check("t4_mis_err", err, 2);
    check("t4_mis_fail_cnt", fail_cnt, 1);
    rom_on = 1'b0;
    run_req(3'd1, rom[1], 1'b0, lat, str, srd);
    check("t4_to_latency", lat, 19);
    check("t4_to_err", err, 3);
    check("t4_to_pass", pass, 0);
    check("t4_to_fail_cnt", fail_cnt, 1);
    check("t4_to_lc_state", lc_state, 0);
    rom_on = 1'b1;

    // 5: reset after 4 of 8 beats
    for (int i = 0; i < 4 && !req_ready; i++) tick();
    req_valid  = 1'b1;
    req_target = 3'd1;
    tick();
    req_valid = 1'b0;
    beats = 0;
    for (int i = 0; i < 20 && beats < 4; i++) begin
      if (tok_ready) begin
        tok_valid = 1'b1;
        tok_data  = rom[1][beats*32 +: 32];
        beats++;
      end else begin
        tok_valid = 1'b0;
      end
      tick();
    end
    tok_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t5_lc_state", lc_state, 0);
    check("t5_fail_cnt", fail_cnt, 0);
    check("t5_err", err, 0);
    check("t5_tok_ready", tok_ready, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_req_ready", req_ready, 1);
    check("t5_done", done, 0);
    rst = 1'b0;
    run_req(3'd1, rom[1], 1'b0, lat, str, srd);
    check("t5_latency", lat, 13);
    check("t5_pass", pass, 1);
    check("t5_lc_state", lc_state, 1);

    // 6: stray tok_valid and mem_valid are ignored
    run_req(3'd2, rom[2], 1'b1, lat, str, srd);
    check("t6_latency", lat, 13);
    check("t6_pass", pass, 1);
    check("t6_err", err, 0);
    check("t6_lc_state", lc_state, 2);
    check("t6_fail_cnt", fail_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc_transition_ctrl.md
Name: lc_transition_ctrl

Overview:
- Lifecycle transition controller; sits directly upstream of the lifecycle token ROM (lc_memory) and is its only reader.
- Accepts a transition request (target state index) plus a WIDTH-bit unlock token, streamed in BEAT-bit beats.
- Reads the reference token for the target from the ROM and compares it against the supplied token.
- Advances the current lifecycle state on a match; counts mismatches and locks out permanently at MAX_FAIL.

Parameters:
WIDTH, 256, token width; must equal the ROM word width
LENGTH, 6, number of lifecycle states / ROM entries
BEAT, 32, token beat width; WIDTH must be a multiple of BEAT
MAX_FAIL, 3, mismatches before permanent lockout
TIMEOUT, 8, cycles to wait for mem_valid after a read

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  transition request
req_ready  out  1  controller can accept a request
req_target  in  $clog2(LENGTH)  requested target state
tok_valid  in  1  token beat valid
tok_ready  out  1  controller accepting token beats
tok_data  in  BEAT  token beat, least-significant beat first
mem_rd_en  out  1  ROM read enable
mem_addr  out  $clog2(LENGTH)  ROM address
mem_rdData  in  WIDTH  ROM read data
mem_valid  in  1  ROM read data valid
lc_state  out  $clog2(LENGTH)  current lifecycle state
done  out  1  one-cycle pulse: request finished
pass  out  1  result of the last request
err  out  2  0 OK, 1 ILLEGAL, 2 MISMATCH, 3 TIMEOUT
fail_cnt  out  $clog2(MAX_FAIL+1)  accumulated mismatches
locked  out  1  permanent lockout

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, lc_state=0, fail_cnt=0, locked=0, pass=0, err=0, done=0, mem_rd_en=0, mem_addr=0, tok_ready=0, token shift register cleared.
- A reset mid-operation abandons the request and discards any partial token.
- req_ready=1 only in IDLE. A request is accepted on the cycle req_valid && req_ready; req_target is latched that cycle.
- pass and err clear on accept and hold their final value after done until the next accept.
- FSM states: IDLE, CHECK, COLLECT, READ, WAIT, COMPARE, DONE, LOCK.
- IDLE -> CHECK: on request accept.
- CHECK, 1 cycle:
  - Legal only if target > lc_state and target < LENGTH (monotonic; target 0 is never legal).
  - Illegal -> DONE with err=1.
  - Legal -> COLLECT.
- COLLECT:
  - tok_ready=1. Each cycle with tok_valid, a beat is written into slot k (bits k*BEAT +: BEAT), k = 0..WIDTH/BEAT-1.
  - After the last beat -> READ. No timeout applies here.
- READ, 1 cycle: mem_rd_en=1, mem_addr=target -> WAIT.
- WAIT:
  - mem_rd_en=0, mem_addr held.
  - On mem_valid, capture mem_rdData -> COMPARE.
  - If mem_valid has not arrived after TIMEOUT cycles in WAIT -> DONE with err=3.
  - A timeout does not increment fail_cnt.
- COMPARE, 1 cycle:
  - Full-width equality check.
  - Equal: lc_state <= target, pass=1, err=0 -> DONE.
  - Not equal: fail_cnt++, err=2. If the new fail_cnt == MAX_FAIL, set locked=1 -> LOCK; else -> DONE.
- DONE: done=1 for exactly 1 cycle -> IDLE.
- LOCK:
  - Terminal until rst. done pulses once on entry.
  - req_ready=0, tok_ready=0, mem_rd_en=0; lc_state frozen.
- Ignored inputs:
  - tok_valid outside COLLECT; mem_valid outside WAIT.
  - req_valid while not in IDLE (not queued).
- The captured ROM word and the assembled token are internal only and never driven on any output.
- Request latency from accept to done, with a ROM that returns data 1 cycle after rd_en and tokens streamed back-to-back: 1 (CHECK) + WIDTH/BEAT + 1 (READ) + 1 (WAIT) + 1 (COMPARE) + 1 (DONE pulse) cycles.

Test Plan:
1. Reset, request target 1, stream 8 beats 0xea56a24a ... 0x33a344a3 (ROM entry 1, LSB beat first) -> done, pass=1, err=0, lc_state=1, fail_cnt=0.
2. From lc_state=1, request target 1, then target 0 -> each gives done with err=1, no tok_ready, no mem_rd_en, lc_state stays 1.
3. Request target 2 with a wrong token three times -> fail_cnt 1, 2, 3; err=2 each time; locked=1 after the third; a further req_valid sees req_ready=0.
4. Hold mem_valid=0, complete a request to target 1 -> done exactly TIMEOUT cycles after WAIT entry, err=3, fail_cnt unchanged.
5. Assert rst after 4 of 8 beats -> all outputs at reset values next cycle; a fresh full request to target 1 passes.
6. Drive tok_valid with junk in IDLE and CHECK, and mem_valid during COLLECT -> ignored; a subsequent correct token still passes.
